decode_sequencer: RTL and testbench
===================================

DECODE_SEQUENCER -- requirements
Module: decode_sequencer

Interface
REQ-001 SHALL have port Clock, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port Reset, input, 1, synchronous active-low reset (0 = reset, sampled on Clock rising edge).
REQ-003 SHALL have port Opcode, input, 5, instruction bits [15:11] from the instruction register.
REQ-004 SHALL have ports Zero (input, 1, ALU equality flag) and MemReady (input, 1, memory completes the current access this cycle).
REQ-005 SHALL have port MemReq, output, 1, memory access request, held high until MemReady.
REQ-006 SHALL have port MemWrite, output, 1, store access, valid while MemReq is high.
REQ-007 SHALL have port MemAddrSel, output, 1: 0 = PC, 1 = ALU result.
REQ-008 SHALL have ports IRWrite (output, 1) and PCWrite (output, 1), plus PCSrc (output, 2): 00 = PC+2, 01 = PC+SEL1, 10 = jump immediate, 11 = A operand.
REQ-009 SHALL have decode-datapath controls, all outputs: RegDest[1:0], RegData[1:0], RsRd[1:0], RsRt[1:0], WriteEnable, HoldOldPCValue, OldNew, UpperLower.
REQ-010 SHALL have outputs InstrDone (1, one-cycle pulse on retire) and Fault (1, sticky illegal-opcode flag).

Function
REQ-011 SHALL implement states FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-012 SHALL, in FETCH: MemReq=1, MemAddrSel=0, HoldOldPCValue=0; on MemReady, IRWrite=1, PCWrite=1, PCSrc=00 for one cycle, then go to DECODE. Without MemReady, stay in FETCH and keep outputs stable.
REQ-013 SHALL, in DECODE: HoldOldPCValue=1 (held until the next FETCH); classify Opcode; go to WB for LUI/LLI, HALT for illegal opcodes, otherwise EXEC.
REQ-014 SHALL decode Opcode as follows:
- 00000-00111 R-ALU: RsRd=00, RsRt=01; then WB with RegDest=00, RegData=01.
- 01000 ADDI: RsRd=01, RsRt=11; then WB with RegDest=01, RegData=01.
- 01001 LUI: WB, RegDest=01, RegData=11, UpperLower=0.
- 01010 LLI: same as LUI but UpperLower=1.
- 01011 LW: EXEC RsRd=01 → MEM read → WB with RegDest=01, RegData=00.
- 01100 SW: EXEC RsRd=01, RsRt=10 → MEM with MemWrite=1 → retire.
- 01101 BEQ: EXEC RsRd=10, RsRt=00; if Zero, PCWrite=1 and PCSrc=01; retire.
- 01110 JAL: EXEC PCWrite=1, PCSrc=10 → WB with RegDest=10, RegData=10, OldNew=0.
- 01111 JR: EXEC RsRd=00, PCWrite=1, PCSrc=11; retire.
- 1xxxx: illegal.
REQ-015 SHALL, in MEM: MemReq=1, MemAddrSel=1; hold the state until MemReady; go to WB (LW) or retire (SW).
REQ-016 SHALL assert WriteEnable for exactly one cycle, in WB only.
REQ-017 SHALL retire by pulsing InstrDone in the final cycle (WB, or EXEC/MEM for BEQ/JR/SW) and go to FETCH next cycle.
REQ-018 SHALL give cycle counts with zero-wait memory: R-ALU/ADDI/JAL 4, LUI/LLI 3, LW 5, SW 4, BEQ/JR 3.
REQ-019 SHALL latch the opcode class at DECODE; changes on Opcode after DECODE are ignored until the next instruction.
REQ-020 SHALL, in HALT: Fault=1, all strobes 0; remain in HALT until reset.
REQ-021 SHALL drive every unused mux select to 00 and every unused strobe to 0 in every state.
REQ-022 SHALL ignore a MemReady that arrives while MemReq=0.

Reset
REQ-023 SHALL, on Reset=0 at a Clock edge, enter FETCH with all strobes 0, all selects 00, Fault=0, InstrDone=0, HoldOldPCValue=0.
REQ-024 SHALL let reset override everything, including mid-MEM and HALT; an interrupted store is abandoned (MemReq drops next cycle).

Structure
REQ-025 SHALL place state encodings, opcode constants and select-value constants in a shared package (merc16_ctrl_pkg).
REQ-026 SHALL use one sub-module, opcode_classifier: combinational, Opcode → class and per-class select values.

Verification
REQ-027 SHALL cover: R-ALU 00011 with MemReady tied 1 → states FETCH, DECODE, EXEC, WB; WriteEnable high one cycle with RegDest=00, RegData=01; InstrDone on cycle 4.
REQ-028 SHALL cover: LW with MemReady delayed 3 cycles in MEM → MemReq held high 3 cycles, MemAddrSel=1, WB RegData=00, total 8 cycles.
REQ-029 SHALL cover: BEQ with Zero=1 → PCWrite=1, PCSrc=01 in EXEC; with Zero=0 → PCWrite=0; both retire in 3 cycles.
REQ-030 SHALL cover: JAL → EXEC PCSrc=10; WB RegDest=10, RegData=10, OldNew=0; HoldOldPCValue=1 from DECODE through WB.
REQ-031 SHALL cover: Opcode 10101 → HALT, Fault=1, no further MemReq; Reset=0 for one cycle → FETCH with Fault=0.
REQ-032 SHALL cover: Reset=0 asserted mid-MEM of SW → next cycle FETCH, MemWrite=0, no InstrDone pulse.

Source files
------------

// File: rtl/merc16_ctrl_pkg.sv
// Shared constants and types for the merc16 multicycle control sequencer:
// state encodings, opcode values, mux select values and the decoded-class record.
package merc16_ctrl_pkg;

   localparam logic [2:0] ST_FETCH  = 3'd0;
   localparam logic [2:0] ST_DECODE = 3'd1;
   localparam logic [2:0] ST_EXEC   = 3'd2;
   localparam logic [2:0] ST_MEM    = 3'd3;
   localparam logic [2:0] ST_WB     = 3'd4;
   localparam logic [2:0] ST_HALT   = 3'd5;

   localparam logic [4:0] OP_ADDI = 5'b01000;
   localparam logic [4:0] OP_LUI  = 5'b01001;
   localparam logic [4:0] OP_LLI  = 5'b01010;
   localparam logic [4:0] OP_LW   = 5'b01011;
   localparam logic [4:0] OP_SW   = 5'b01100;
   localparam logic [4:0] OP_BEQ  = 5'b01101;
   localparam logic [4:0] OP_JAL  = 5'b01110;
   localparam logic [4:0] OP_JR   = 5'b01111;

   localparam logic [1:0] SEL_00 = 2'b00;
   localparam logic [1:0] SEL_01 = 2'b01;
   localparam logic [1:0] SEL_10 = 2'b10;
   localparam logic [1:0] SEL_11 = 2'b11;

   localparam logic [1:0] PCSRC_INC    = 2'b00;
   localparam logic [1:0] PCSRC_BRANCH = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;
   localparam logic [1:0] PCSRC_REG    = 2'b11;

   typedef enum logic [3:0] {
      CLS_RALU, CLS_ADDI, CLS_LUI, CLS_LLI, CLS_LW,
      CLS_SW, CLS_BEQ, CLS_JAL, CLS_JR, CLS_ILL
   } op_class_t;

   typedef struct packed {
      op_class_t  cls;
      logic [1:0] rs_rd;
      logic [1:0] rs_rt;
      logic [1:0] reg_dest;
      logic [1:0] reg_data;
      logic       upper_lower;
      logic       old_new;
   } op_decode_t;

endpackage

// File: rtl/opcode_classifier.sv
// Combinational opcode decode: instruction class plus the register-file and
// write-back select values that class uses.
module opcode_classifier
   import merc16_ctrl_pkg::*;
(
   input  logic [4:0] opcode,
   output op_decode_t dec
);

   always_comb begin
      dec     = '0;
      dec.cls = CLS_ILL;
      if (opcode[4:3] == 2'b00) begin
         dec.cls      = CLS_RALU;
         dec.rs_rt    = SEL_01;
         dec.reg_data = SEL_01;
      end else begin
         case (opcode)
            OP_ADDI: begin
               dec.cls      = CLS_ADDI;
               dec.rs_rd    = SEL_01;
               dec.rs_rt    = SEL_11;
               dec.reg_dest = SEL_01;
               dec.reg_data = SEL_01;
            end
            OP_LUI, OP_LLI: begin
               dec.cls         = (opcode == OP_LLI) ? CLS_LLI : CLS_LUI;
               dec.reg_dest    = SEL_01;
               dec.reg_data    = SEL_11;
               dec.upper_lower = (opcode == OP_LLI);
            end
            OP_LW: begin
               dec.cls      = CLS_LW;
               dec.rs_rd    = SEL_01;
               dec.reg_dest = SEL_01;
            end
            OP_SW: begin
               dec.cls   = CLS_SW;
               dec.rs_rd = SEL_01;
               dec.rs_rt = SEL_10;
            end
            OP_BEQ: begin
               dec.cls   = CLS_BEQ;
               dec.rs_rd = SEL_10;
            end
            OP_JAL: begin
               dec.cls      = CLS_JAL;
               dec.reg_dest = SEL_10;
               dec.reg_data = SEL_10;
            end
            OP_JR:   dec.cls = CLS_JR;
            default: dec.cls = CLS_ILL;
         endcase
      end
   end

endmodule

// File: rtl/decode_sequencer.sv
// Multicycle control FSM: FETCH -> DECODE -> EXEC/MEM/WB per instruction class,
// with a sticky HALT on illegal opcodes. The current state is exposed on 'state'.
module decode_sequencer
   import merc16_ctrl_pkg::*;
(
   input  logic       Clock,
   input  logic       Reset,
   input  logic [4:0] Opcode,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       MemReq,
   output logic       MemWrite,
   output logic       MemAddrSel,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic [1:0] PCSrc,
   output logic [1:0] RegDest,
   output logic [1:0] RegData,
   output logic [1:0] RsRd,
   output logic [1:0] RsRt,
   output logic       WriteEnable,
   output logic       HoldOldPCValue,
   output logic       OldNew,
   output logic       UpperLower,
   output logic       InstrDone,
   output logic       Fault,
   output logic [2:0] state
);

   op_decode_t dec_now;
   op_decode_t dec_q;
   logic [2:0] next_state;
   logic       active;

   opcode_classifier u_classifier (
      .opcode (Opcode),
      .dec    (dec_now)
   );

   // 'active' keeps every strobe low for the first cycle after reset, so a
   // reset mid-access drops MemReq immediately instead of restarting a fetch.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state  <= ST_FETCH;
         active <= 1'b0;
         dec_q  <= '0;
      end else begin
         state  <= next_state;
         active <= 1'b1;
         if (state == ST_DECODE) dec_q <= dec_now;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_FETCH:  if (active && MemReady) next_state = ST_DECODE;
         ST_DECODE: begin
            case (dec_now.cls)
               CLS_LUI, CLS_LLI: next_state = ST_WB;
               CLS_ILL:          next_state = ST_HALT;
               default:          next_state = ST_EXEC;
            endcase
         end
         ST_EXEC: begin
            case (dec_q.cls)
               CLS_LW, CLS_SW:             next_state = ST_MEM;
               CLS_RALU, CLS_ADDI, CLS_JAL: next_state = ST_WB;
               default:                    next_state = ST_FETCH;
            endcase
         end
         ST_MEM: begin
            if (MemReady) next_state = (dec_q.cls == CLS_LW) ? ST_WB : ST_FETCH;
         end
         ST_WB:   next_state = ST_FETCH;
         ST_HALT: next_state = ST_HALT;
         default: next_state = ST_FETCH;
      endcase
   end

   always_comb begin
      MemReq         = 1'b0;
      MemWrite       = 1'b0;
      MemAddrSel     = 1'b0;
      IRWrite        = 1'b0;
      PCWrite        = 1'b0;
      PCSrc          = PCSRC_INC;
      RegDest        = SEL_00;
      RegData        = SEL_00;
      RsRd           = SEL_00;
      RsRt           = SEL_00;
      WriteEnable    = 1'b0;
      HoldOldPCValue = 1'b0;
      OldNew         = 1'b0;
      UpperLower     = 1'b0;
      InstrDone      = 1'b0;
      Fault          = 1'b0;
      case (state)
         ST_FETCH: begin
            if (active) begin
               MemReq = 1'b1;
               if (MemReady) begin
                  IRWrite = 1'b1;
                  PCWrite = 1'b1;
               end
            end
         end
         ST_DECODE: HoldOldPCValue = 1'b1;
         ST_EXEC: begin
            HoldOldPCValue = 1'b1;
            RsRd           = dec_q.rs_rd;
            RsRt           = dec_q.rs_rt;
            case (dec_q.cls)
               CLS_BEQ: begin
                  InstrDone = 1'b1;
                  if (Zero) begin
                     PCWrite = 1'b1;
                     PCSrc   = PCSRC_BRANCH;
                  end
               end
               CLS_JAL: begin
                  PCWrite = 1'b1;
                  PCSrc   = PCSRC_JUMP;
               end
               CLS_JR: begin
                  PCWrite   = 1'b1;
                  PCSrc     = PCSRC_REG;
                  InstrDone = 1'b1;
               end
               default: ;
            endcase
         end
         ST_MEM: begin
            HoldOldPCValue = 1'b1;
            MemReq         = 1'b1;
            MemAddrSel     = 1'b1;
            MemWrite       = (dec_q.cls == CLS_SW);
            InstrDone      = MemReady && (dec_q.cls == CLS_SW);
         end
         ST_WB: begin
            HoldOldPCValue = 1'b1;
            WriteEnable    = 1'b1;
            RegDest        = dec_q.reg_dest;
            RegData        = dec_q.reg_data;
            UpperLower     = dec_q.upper_lower;
            OldNew         = dec_q.old_new;
            InstrDone      = 1'b1;
         end
         ST_HALT: Fault = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_decode_sequencer.sv
// Directed bench for decode_sequencer: a table of per-opcode expectations run
// with zero-wait memory, plus hand sequences for wait states, halt and reset.
module tb_decode_sequencer;
   import merc16_ctrl_pkg::*;

   logic       Clock = 1'b0;
   logic       Reset = 1'b0;
   logic [4:0] Opcode = 5'b0;
   logic       Zero = 1'b0;
   logic       MemReady = 1'b0;
   logic       MemReq, MemWrite, MemAddrSel, IRWrite, PCWrite;
   logic [1:0] PCSrc, RegDest, RegData, RsRd, RsRt;
   logic       WriteEnable, HoldOldPCValue, OldNew, UpperLower, InstrDone, Fault;
   logic [2:0] state;

   decode_sequencer dut (
      .Clock(Clock), .Reset(Reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
      .MemReq(MemReq), .MemWrite(MemWrite), .MemAddrSel(MemAddrSel), .IRWrite(IRWrite),
      .PCWrite(PCWrite), .PCSrc(PCSrc), .RegDest(RegDest), .RegData(RegData),
      .RsRd(RsRd), .RsRt(RsRt), .WriteEnable(WriteEnable), .HoldOldPCValue(HoldOldPCValue),
      .OldNew(OldNew), .UpperLower(UpperLower), .InstrDone(InstrDone), .Fault(Fault),
      .state(state)
   );

   // clock / watchdog
   always #5 Clock = ~Clock;
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [2:0] st;
      logic       mreq, mwr, masel, irw, pcw, we, hold, oldnew, ul, done;
      logic [1:0] pcsrc, rdest, rdata, rsrd, rsrt;
   } snap_t;

   typedef struct {
      string      name;
      logic [4:0] op;
      logic       zero;
      int         cycles;
      logic       has_exec, has_mem, has_wb;
      logic [1:0] rs_rd, rs_rt;
      logic       exec_pcw;
      logic [1:0] exec_pcsrc, reg_dest, reg_data;
      logic       ul;
   } vec_t;

   snap_t      log_a[64];
   int         n_log;
   logic [2:0] exp_q[$];
   vec_t       vecs[12];
   int         checks = 0;
   int         failures = 0;

   // scoreboard compare
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   // driver: runs one instruction from FETCH, logging every cycle until InstrDone
   task automatic run_instr(input logic [4:0] op, input logic [4:0] op_late,
                            input logic z, input int mem_wait);
      int   mem_cnt;
      logic done;
      mem_cnt = 0;
      done    = 1'b0;
      n_log   = 0;
      Opcode  = op;
      Zero    = z;
      while (!done && n_log < 40) begin
         if (n_log >= 2) Opcode = op_late;
         MemReady = (state != ST_MEM) || (mem_cnt >= mem_wait);
         if (state == ST_MEM) mem_cnt++;
         #1;
         log_a[n_log].st     = state;
         log_a[n_log].mreq   = MemReq;
         log_a[n_log].mwr    = MemWrite;
         log_a[n_log].masel  = MemAddrSel;
         log_a[n_log].irw    = IRWrite;
         log_a[n_log].pcw    = PCWrite;
         log_a[n_log].pcsrc  = PCSrc;
         log_a[n_log].rdest  = RegDest;
         log_a[n_log].rdata  = RegData;
         log_a[n_log].rsrd   = RsRd;
         log_a[n_log].rsrt   = RsRt;
         log_a[n_log].we     = WriteEnable;
         log_a[n_log].hold   = HoldOldPCValue;
         log_a[n_log].oldnew = OldNew;
         log_a[n_log].ul     = UpperLower;
         log_a[n_log].done   = InstrDone;
         n_log++;
         done = InstrDone;
         @(posedge Clock);
         #1;
      end
      MemReady = 1'b1;
   endtask

   task automatic check_vec(input vec_t v, input int mem_wait);
      int n_done, n_we, n_hold_bad, n_quiet_bad, last;
      logic [2:0] e;
      exp_q.push_back(ST_FETCH);
      exp_q.push_back(ST_DECODE);
      if (v.has_exec) exp_q.push_back(ST_EXEC);
      if (v.has_mem) for (int i = 0; i <= mem_wait; i++) exp_q.push_back(ST_MEM);
      if (v.has_wb) exp_q.push_back(ST_WB);
      check({v.name, "_cycles"}, n_log, v.cycles);
      for (int i = 0; i < n_log; i++) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 3'h7;
         check($sformatf("%s_state%0d", v.name, i), log_a[i].st, e);
      end
      exp_q.delete();
      check({v.name, "_fetch"}, {log_a[0].mreq, log_a[0].masel, log_a[0].irw,
            log_a[0].pcw, log_a[0].pcsrc, log_a[0].hold}, 7'b1011000);
      last = n_log - 1;
      n_done = 0; n_we = 0; n_hold_bad = 0; n_quiet_bad = 0;
      for (int i = 0; i < n_log; i++) begin
         n_done += int'(log_a[i].done);
         n_we   += int'(log_a[i].we);
         if (i >= 1 && log_a[i].hold !== 1'b1) n_hold_bad++;
         if (i != last && (log_a[i].rdest != 2'b00 || log_a[i].rdata != 2'b00 || log_a[i].ul)) n_quiet_bad++;
         if (!(v.has_exec && i == 2) && (log_a[i].rsrd != 2'b00 || log_a[i].rsrt != 2'b00)) n_quiet_bad++;
         if (!(v.has_mem && i >= 3) && log_a[i].mwr) n_quiet_bad++;
      end
      check({v.name, "_done_count"}, n_done, 1);
      check({v.name, "_done_last"}, log_a[last].done, 1'b1);
      check({v.name, "_we_count"}, n_we, v.has_wb ? 1 : 0);
      check({v.name, "_hold"}, n_hold_bad, 0);
      check({v.name, "_quiet"}, n_quiet_bad, 0);
      if (v.has_exec && n_log > 2)
         check({v.name, "_exec"}, {log_a[2].rsrd, log_a[2].rsrt, log_a[2].pcw, log_a[2].pcsrc},
               {v.rs_rd, v.rs_rt, v.exec_pcw, v.exec_pcsrc});
      if (v.has_mem)
         for (int i = 3; i <= 3 + mem_wait && i < n_log; i++)
            check($sformatf("%s_mem%0d", v.name, i), {log_a[i].mreq, log_a[i].masel, log_a[i].mwr},
                  {2'b11, !v.has_wb});
      if (v.has_wb)
         check({v.name, "_wb"}, {log_a[last].rdest, log_a[last].rdata, log_a[last].ul, log_a[last].oldnew},
               {v.reg_dest, v.reg_data, v.ul, 1'b0});
   endtask

   initial begin
      vec_t lw_slow;
      int   n_bad, k;
      //            name      op        z     cyc ex    mem   wb    rsrd   rsrt   pcw   pcsrc  rdest  rdata  ul
      vecs[0]  = '{"ralu3",  5'b00011, 1'b0, 4, 1'b1, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0};
      vecs[1]  = '{"ralu0",  5'b00000, 1'b0, 4, 1'b1, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0};
      vecs[2]  = '{"ralu7",  5'b00111, 1'b1, 4, 1'b1, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0};
      vecs[3]  = '{"addi",   5'b01000, 1'b0, 4, 1'b1, 1'b0, 1'b1, 2'b01, 2'b11, 1'b0, 2'b00, 2'b01, 2'b01, 1'b0};
      vecs[4]  = '{"lui",    5'b01001, 1'b0, 3, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 2'b01, 2'b11, 1'b0};
      vecs[5]  = '{"lli",    5'b01010, 1'b0, 3, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 2'b01, 2'b11, 1'b1};
      vecs[6]  = '{"lw",     5'b01011, 1'b0, 5, 1'b1, 1'b1, 1'b1, 2'b01, 2'b00, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0};
      vecs[7]  = '{"sw",     5'b01100, 1'b0, 4, 1'b1, 1'b1, 1'b0, 2'b01, 2'b10, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
      vecs[8]  = '{"beq_t",  5'b01101, 1'b1, 3, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 1'b1, 2'b01, 2'b00, 2'b00, 1'b0};
      vecs[9]  = '{"beq_nt", 5'b01101, 1'b0, 3, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
      vecs[10] = '{"jal",    5'b01110, 1'b0, 4, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 2'b10, 2'b10, 2'b10, 1'b0};
      vecs[11] = '{"jr",     5'b01111, 1'b0, 3, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b11, 2'b00, 2'b00, 1'b0};

      // reset: FETCH with every strobe low, MemReady ignored while MemReq=0
      Reset = 1'b0; MemReady = 1'b1;
      tick(); tick();
      check("rst_state", state, ST_FETCH);
      check("rst_outs", {MemReq, IRWrite, PCWrite, WriteEnable, InstrDone, Fault, HoldOldPCValue}, 7'b0);
      Reset = 1'b1;
      tick();
      check("rst_ignore_ready", state, ST_FETCH);
      check("rst_fetch_req", MemReq, 1'b1);

      for (int i = 0; i < 12; i++) begin
         run_instr(vecs[i].op, vecs[i].op, vecs[i].zero, 0);
         check_vec(vecs[i], 0);
      end

      // LW with three wait cycles in MEM
      lw_slow = vecs[6];
      lw_slow.name = "lw_wait3";
      lw_slow.cycles = 8;
      run_instr(lw_slow.op, lw_slow.op, 1'b0, 3);
      check_vec(lw_slow, 3);

      // opcode changes after DECODE must not affect the running R-ALU instruction
      run_instr(5'b00011, OP_SW, 1'b0, 0);
      vecs[0].name = "ralu_late_op";
      check_vec(vecs[0], 0);

      // illegal opcode: HALT is sticky and silent until reset
      Opcode = 5'b10101; MemReady = 1'b1;
      tick(); tick();
      check("halt_state", state, ST_HALT);
      check("halt_fault", Fault, 1'b1);
      n_bad = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (state !== ST_HALT || MemReq || IRWrite || PCWrite || WriteEnable || InstrDone || !Fault) n_bad++;
      end
      check("halt_quiet", n_bad, 0);
      Opcode = 5'b00011;
      Reset = 1'b0;
      tick();
      check("halt_rst_state", state, ST_FETCH);
      check("halt_rst_outs", {Fault, MemReq, HoldOldPCValue}, 3'b0);
      Reset = 1'b1;
      tick();
      check("halt_rst_fetch", MemReq, 1'b1);

      // reset in the middle of a stalled store
      Opcode = OP_SW; MemReady = 1'b1;
      k = 0;
      while (state !== ST_MEM && k < 10) begin
         tick();
         k++;
      end
      check("sw_reach_mem", state, ST_MEM);
      MemReady = 1'b0;
      #1;
      check("sw_mem_outs", {MemReq, MemWrite, InstrDone}, 3'b110);
      Reset = 1'b0;
      tick();
      check("sw_rst_state", state, ST_FETCH);
      check("sw_rst_outs", {MemReq, MemWrite, InstrDone}, 3'b000);
      Reset = 1'b1; MemReady = 1'b1;
      tick();
      run_instr(5'b00011, 5'b00011, 1'b0, 0);
      vecs[0].name = "ralu_after_rst";
      check_vec(vecs[0], 0);

      // final report
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
